msg_streamer: RTL and testbench

MSG_STREAMER -- requirements
Module: msg_streamer

---
 rtl/msg_streamer.sv | 134 +++++++++++++
 tb/tb_msg_streamer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/msg_streamer.sv
// msg_streamer: emits "Hello, world!\nTime is: <T>\n" on a valid/ready byte stream, T = cycle counter at start.
// Optional greeting line enabled by defining MSG_STREAMER_GREET_EN.
module msg_streamer #(
    parameter int TIME_W = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy,
    output logic       done
);
    localparam int ND = TIME_W * 77 / 256 + 1;
    localparam int BW = 4 * ND;
    localparam logic [8*9-1:0] PREFIX_MSG = "Time is: ";
`ifdef MSG_STREAMER_GREET_EN
    localparam logic [8*14-1:0] GREET_MSG = "Hello, world!\n";
`endif

    typedef enum logic [2:0] {
        IDLE,
`ifdef MSG_STREAMER_GREET_EN
        GREET,
`endif
        PREFIX,
        CONV,
        DIGITS,
        NL,
        FIN
    } state_t;

    state_t              state_q, state_d;
    logic [TIME_W-1:0]   cnt_q, t_q, t_d, sh_q, sh_d;
    logic [BW-1:0]       bcd_q, bcd_d, adj, conv_bcd;
    logic [5:0]          idx_q, idx_d, lead;
    logic                fire;

    always_comb begin
        adj = bcd_q;
        for (int i = 0; i < ND; i++)
            adj[4*i +: 4] = (adj[4*i +: 4] > 4'd4) ? adj[4*i +: 4] + 4'd3 : adj[4*i +: 4];
        conv_bcd = {adj[BW-2:0], sh_q[TIME_W-1]};
        // Index of the most significant non-zero digit; 0 keeps a lone "0"
        lead = '0;
        for (int i = 0; i < ND; i++)
            if (conv_bcd[4*i +: 4] != 4'd0) lead = 6'(i);
    end

    assign fire = out_valid && out_ready;
    assign busy = state_q != IDLE;
    assign done = state_q == FIN;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        t_d       = t_q;
        sh_d      = sh_q;
        bcd_d     = bcd_q;
        out_data  = 8'h00;
        out_valid = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                t_d   = cnt_q;
                sh_d  = cnt_q;
                bcd_d = '0;
                idx_d = '0;
`ifdef MSG_STREAMER_GREET_EN
                state_d = GREET;
`else
                state_d = PREFIX;
`endif
            end
`ifdef MSG_STREAMER_GREET_EN
            GREET: begin
                out_valid = 1'b1;
                out_data  = GREET_MSG[(13 - int'(idx_q))*8 +: 8];
                if (fire) begin
                    idx_d   = (idx_q == 6'd13) ? 6'd0 : idx_q + 6'd1;
                    state_d = (idx_q == 6'd13) ? PREFIX : GREET;
                end
            end
`endif
            PREFIX: begin
                out_valid = 1'b1;
                out_data  = PREFIX_MSG[(8 - int'(idx_q))*8 +: 8];
                if (fire) begin
                    idx_d   = (idx_q == 6'd8) ? 6'd0 : idx_q + 6'd1;
                    state_d = (idx_q == 6'd8) ? CONV : PREFIX;
                end
            end
            CONV: begin
                bcd_d   = conv_bcd;
                sh_d    = sh_q << 1;
                idx_d   = (idx_q == 6'(TIME_W-1)) ? lead : idx_q + 6'd1;
                state_d = (idx_q == 6'(TIME_W-1)) ? DIGITS : CONV;
            end
            DIGITS: begin
                out_valid = 1'b1;
                out_data  = {4'h3, bcd_q[4*int'(idx_q) +: 4]};
                if (fire) begin
                    idx_d   = (idx_q == 6'd0) ? 6'd0 : idx_q - 6'd1;
                    state_d = (idx_q == 6'd0) ? NL : DIGITS;
                end
            end
            NL: begin
                out_valid = 1'b1;
                out_data  = 8'h0A;
                if (fire) state_d = FIN;
            end
            FIN: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            t_q     <= '0;
            sh_q    <= '0;
            bcd_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_q + 1'b1;
            t_q     <= t_d;
            sh_q    <= sh_d;
            bcd_q   <= bcd_d;
            idx_q   <= idx_d;
        end
    end
endmodule

// File: tb/tb_msg_streamer.sv
// tb_msg_streamer: directed checks of msg_streamer at TIME_W=16 (dut_a) and TIME_W=4 (dut_b).
module tb_msg_streamer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       ready = 1'b1;
    logic [7:0] data_a, data_b;
    logic       valid_a, valid_b, busy_a, busy_b, done_a, done_b;
    int         checks = 0;
    int         failures = 0;

    msg_streamer #(.TIME_W(16)) dut_a (
        .clk(clk), .rst(rst), .start(start), .out_data(data_a), .out_valid(valid_a),
        .out_ready(ready), .busy(busy_a), .done(done_a)
    );
    msg_streamer #(.TIME_W(4)) dut_b (
        .clk(clk), .rst(rst), .start(start), .out_data(data_b), .out_valid(valid_b),
        .out_ready(ready), .busy(busy_b), .done(done_b)
    );

    always #5 clk = ~clk;

    function automatic string hdr();
`ifdef MSG_STREAMER_GREET_EN
        return "Hello, world!\n";
`else
        return "";
`endif
    endfunction

    task automatic reset_to(input int k);
        start = 1'b0;
        ready = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (k) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Collects the transferred bytes of one message from the selected instance
    task automatic capture(input bit sel, input bit stall, input bit spam,
                           output string got, output int dones, output int stall_err);
        logic [7:0] d, prev_d;
        logic v, dn, prev_stall;
        int after;
        got = "";
        dones = 0;
        stall_err = 0;
        prev_stall = 1'b0;
        prev_d = 8'h00;
        after = -1;
        for (int c = 0; c < 800; c++) begin
            v  = sel ? valid_b : valid_a;
            d  = sel ? data_b : data_a;
            dn = sel ? done_b : done_a;
            if (prev_stall && (!v || d != prev_d)) stall_err++;
            if (dn) dones++;
            if (dones > 0) after++;
            if (after >= 3) break;
            ready = stall ? (c % 3 == 0) : 1'b1;
            start = spam && (c % 4 == 1) && (c < 20);
            if (v && ready) got = $sformatf("%s%c", got, d);
            prev_stall = v && !ready;
            prev_d = d;
            @(negedge clk);
        end
        start = 1'b0;
        ready = 1'b1;
        if (after < 3) got = {got, "<timeout>"};
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (valid_a !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", valid_a); end
        checks++; if (data_a !== 8'h00) begin failures++; $display("FAIL reset_data got=%h want=00", data_a); end
        checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy_a); end
        checks++; if (done_a !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", done_a); end
        checks++; if (dut_a.cnt_q !== 16'd0) begin failures++; $display("FAIL reset_cnt got=%0d want=0", dut_a.cnt_q); end
    endtask

    task automatic test_basic();
        string got, exp;
        int dones, serr;
        reset_to(5);
        exp = {hdr(), "Time is: 5\n"};
        checks++; if (dut_a.cnt_q !== 16'd5) begin failures++; $display("FAIL basic_cnt got=%0d want=5", dut_a.cnt_q); end
        pulse_start();
        checks++; if (busy_a !== 1'b1) begin failures++; $display("FAIL basic_busy got=%b want=1", busy_a); end
        capture(1'b0, 1'b0, 1'b0, got, dones, serr);
        checks++; if (got != exp) begin failures++; $display("FAIL basic_msg got=\"%s\" want=\"%s\"", got, exp); end
        checks++; if (dones != 1) begin failures++; $display("FAIL basic_done got=%0d want=1", dones); end
        checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL basic_idle got=%b want=0", busy_a); end
    endtask

    task automatic test_zero();
        string got, exp;
        int dones, serr;
        reset_to(0);
        exp = {hdr(), "Time is: 0\n"};
        pulse_start();
        capture(1'b0, 1'b0, 1'b0, got, dones, serr);
        checks++; if (got != exp) begin failures++; $display("FAIL zero_msg got=\"%s\" want=\"%s\"", got, exp); end
        checks++; if (dones != 1) begin failures++; $display("FAIL zero_done got=%0d want=1", dones); end
    endtask

    task automatic test_stall();
        string got, exp;
        int dones, serr;
        reset_to(40);
        exp = {hdr(), "Time is: 40\n"};
        pulse_start();
        capture(1'b0, 1'b1, 1'b0, got, dones, serr);
        checks++; if (got != exp) begin failures++; $display("FAIL stall_msg got=\"%s\" want=\"%s\"", got, exp); end
        checks++; if (serr != 0) begin failures++; $display("FAIL stall_hold got=%0d unstable want=0", serr); end
        checks++; if (dones != 1) begin failures++; $display("FAIL stall_done got=%0d want=1", dones); end
    endtask

    task automatic test_wrap4();
        string got, exp;
        int dones, serr;
        reset_to(15);
        exp = {hdr(), "Time is: 15\n"};
        checks++; if (dut_b.cnt_q !== 4'd15) begin failures++; $display("FAIL wrap_cnt15 got=%0d want=15", dut_b.cnt_q); end
        pulse_start();
        checks++; if (dut_b.cnt_q !== 4'd0) begin failures++; $display("FAIL wrap_cnt0 got=%0d want=0", dut_b.cnt_q); end
        capture(1'b1, 1'b0, 1'b0, got, dones, serr);
        checks++; if (got != exp) begin failures++; $display("FAIL wrap_msg got=\"%s\" want=\"%s\"", got, exp); end
    endtask

    task automatic test_reset_mid();
        string got, exp, first;
        int dones, serr;
        logic [7:0] third;
        reset_to(2);
        first = {hdr(), "Time is: "};
        third = first[2];
        pulse_start();
        repeat (2) @(negedge clk);
        checks++; if (data_a !== third) begin failures++; $display("FAIL mid_third got=%h want=%h", data_a, third); end
        rst = 1'b1;
        #1;
        checks++; if (valid_a !== 1'b0 || data_a !== 8'h00) begin failures++; $display("FAIL mid_out got=%b/%h want=0/00", valid_a, data_a); end
        checks++; if (busy_a !== 1'b0 || done_a !== 1'b0) begin failures++; $display("FAIL mid_busy got=%b/%b want=0/0", busy_a, done_a); end
        checks++; if (dut_a.cnt_q !== 16'd0) begin failures++; $display("FAIL mid_cnt got=%0d want=0", dut_a.cnt_q); end
        @(negedge clk);
        rst = 1'b0;
        repeat (7) @(negedge clk);
        exp = {hdr(), "Time is: 7\n"};
        pulse_start();
        capture(1'b0, 1'b0, 1'b0, got, dones, serr);
        checks++; if (got != exp) begin failures++; $display("FAIL mid_restart got=\"%s\" want=\"%s\"", got, exp); end
    endtask

    task automatic test_busy_ignore();
        string got, exp;
        int dones, serr, extra;
        reset_to(123);
        exp = {hdr(), "Time is: 123\n"};
        pulse_start();
        capture(1'b0, 1'b0, 1'b1, got, dones, serr);
        checks++; if (got != exp) begin failures++; $display("FAIL ignore_msg got=\"%s\" want=\"%s\"", got, exp); end
        extra = 0;
        repeat (10) begin
            if (busy_a || valid_a) extra++;
            @(negedge clk);
        end
        checks++; if (extra != 0) begin failures++; $display("FAIL ignore_extra got=%0d busy cycles want=0", extra); end
        checks++; if (dones != 1) begin failures++; $display("FAIL ignore_done got=%0d want=1", dones); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero();
        test_stall();
        test_wrap4();
        test_reset_mid();
        test_busy_ignore();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
